// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared definitions for the LED pattern sequencer: FSM state encoding,
// register offsets relative to the sequencer base address, MODE encodings
// and the pattern advance function.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

    localparam logic [7:0] CTRL_OFS   = 8'd0;
    localparam logic [7:0] PERIOD_OFS = 8'd1;
    localparam logic [7:0] SEEDLO_OFS = 8'd2;
    localparam logic [7:0] SEEDHI_OFS = 8'd3;

    localparam logic MODE_ROTATE = 1'b0;
    localparam logic MODE_INCR   = 1'b1;

    // One animation step: rotate-left by one, or increment with wrap.
    function automatic logic [15:0] next_pattern(input logic [15:0] p, input logic mode);
        return (mode == MODE_INCR) ? p + 16'd1 : {p[14:0], p[15]};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running counter 0..TERMINAL that pulses TICK for one cycle at the
// terminal count, i.e. one tick every TERMINAL+1 enabled cycles.
// Ports:
//   CLK   - system clock
//   RESET - asynchronous active-high reset
//   EN    - count enable
//   CLR   - synchronous clear (takes priority over EN)
//   TICK  - one-cycle pulse at the terminal count
module tick_prescaler #(
    parameter int unsigned TERMINAL = 99_999
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int W = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);

    logic [W-1:0] count;
    logic         at_terminal;

    assign at_terminal = (count == W'(TERMINAL));
    assign TICK        = EN && !CLR && at_terminal;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (EN) begin
            count <= at_terminal ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Animates the 16-bit LED peripheral by writing a pattern as a low/high
// byte pair, sharing the peripheral write bus with the CPU. CPU writes
// always pass through; sequencer writes fill cycles with no CPU write.
// Ports:
//   CLK        - system clock
//   RESET      - asynchronous active-high reset
//   CPU_ADDR   - CPU bus address
//   CPU_DATA   - CPU bus write data
//   CPU_WE     - CPU write strobe
//   BUS_ADDR   - registered address to the LED peripheral
//   BUS_DATA   - registered data to the LED peripheral
//   BUS_WE     - registered one-cycle write strobe to the LED peripheral
//   SEQ_ACTIVE - high whenever the FSM is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | sequencer off, prescaler held clear
// WR_LO    | waiting for a free bus cycle to write pattern[7:0]
// WR_HI    | waiting for a free bus cycle to write pattern[15:8]
// WAIT     | counting ticks until the next step
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter logic [7:0]  SeqBaseAddress = 8'hC4,
    parameter logic [7:0]  LedBaseAddress = 8'hC0,
    parameter int unsigned PrescaleMax    = 99_999
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CPU_ADDR,
    input  logic [7:0] CPU_DATA,
    input  logic       CPU_WE,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       SEQ_ACTIVE
);

    seq_state_t  state;
    logic        ctrl_en;
    logic        ctrl_mode;
    logic [7:0]  period_reg;
    logic [7:0]  period_cnt;
    logic [15:0] pattern;

    logic        wr_ctrl, wr_period, wr_seed_lo, wr_seed_hi;
    logic        en_next;
    logic [7:0]  period_eff;
    logic        tick;
    logic        expire;

    assign wr_ctrl    = CPU_WE && (CPU_ADDR == SeqBaseAddress + CTRL_OFS);
    assign wr_period  = CPU_WE && (CPU_ADDR == SeqBaseAddress + PERIOD_OFS);
    assign wr_seed_lo = CPU_WE && (CPU_ADDR == SeqBaseAddress + SEEDLO_OFS);
    assign wr_seed_hi = CPU_WE && (CPU_ADDR == SeqBaseAddress + SEEDHI_OFS);

    // IDLE looks at the value being written so WR_LO is entered on the same
    // edge that sets EN.
    assign en_next    = wr_ctrl ? CPU_DATA[0] : ctrl_en;
    assign period_eff = (period_reg == 8'd0) ? 8'd1 : period_reg;
    assign expire     = (state == ST_WAIT) && ctrl_en && tick &&
                        (period_cnt == period_eff - 8'd1);

    tick_prescaler #(
        .TERMINAL (PrescaleMax)
    ) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (state != ST_IDLE),
        .CLR   (state == ST_IDLE),
        .TICK  (tick)
    );

    // Register file, pattern and period counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_en    <= 1'b0;
            ctrl_mode  <= MODE_ROTATE;
            period_reg <= 8'd0;
            period_cnt <= 8'd0;
            pattern    <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= CPU_DATA[0];
                ctrl_mode <= CPU_DATA[1];
            end
            if (wr_period) begin
                period_reg <= CPU_DATA;
            end
            // A seed write in the expiry cycle drops that advance entirely.
            if (wr_seed_lo || wr_seed_hi) begin
                if (wr_seed_lo) pattern[7:0]  <= CPU_DATA;
                if (wr_seed_hi) pattern[15:8] <= CPU_DATA;
            end else if (expire) begin
                pattern <= next_pattern(pattern, ctrl_mode);
            end
            if ((state != ST_WAIT) || expire || wr_period || wr_seed_lo || wr_seed_hi) begin
                period_cnt <= 8'd0;
            end else if (tick) begin
                period_cnt <= period_cnt + 8'd1;
            end
        end
    end

    // FSM with registered bus mux; the CPU always wins the bus.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            BUS_ADDR   <= 8'd0;
            BUS_DATA   <= 8'd0;
            BUS_WE     <= 1'b0;
            SEQ_ACTIVE <= 1'b0;
        end else begin
            BUS_WE <= 1'b0;
            if (CPU_WE) begin
                BUS_ADDR <= CPU_ADDR;
                BUS_DATA <= CPU_DATA;
                BUS_WE   <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (en_next) begin
                        state      <= ST_WR_LO;
                        SEQ_ACTIVE <= 1'b1;
                    end
                end
                ST_WR_LO: begin
                    if (!CPU_WE) begin
                        BUS_ADDR <= LedBaseAddress;
                        BUS_DATA <= pattern[7:0];
                        BUS_WE   <= 1'b1;
                        state    <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    if (!CPU_WE) begin
                        BUS_ADDR   <= LedBaseAddress + 8'd1;
                        BUS_DATA   <= pattern[15:8];
                        BUS_WE     <= 1'b1;
                        state      <= ctrl_en ? ST_WAIT : ST_IDLE;
                        SEQ_ACTIVE <= ctrl_en;
                    end
                end
                ST_WAIT: begin
                    if (!ctrl_en) begin
                        state      <= ST_IDLE;
                        SEQ_ACTIVE <= 1'b0;
                    end else if (expire) begin
                        state <= ST_WR_LO;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    SEQ_ACTIVE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Scoreboard bench: stimulus pushes expected bus writes into queues, a
// negedge monitor pops and compares whenever BUS_WE is seen. Expected
// sequencer patterns come from a plain-arithmetic step model.
module tb_led_pattern_sequencer;

    localparam int unsigned PM = 3;

    logic       CLK;
    logic       RESET;
    logic [7:0] CPU_ADDR;
    logic [7:0] CPU_DATA;
    logic       CPU_WE;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       SEQ_ACTIVE;

    led_pattern_sequencer #(
        .SeqBaseAddress (8'hC4),
        .LedBaseAddress (8'hC0),
        .PrescaleMax    (PM)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_DATA   (CPU_DATA),
        .CPU_WE     (CPU_WE),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_DATA   (BUS_DATA),
        .BUS_WE     (BUS_WE),
        .SEQ_ACTIVE (SEQ_ACTIVE)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         c;
    } wr_t;

    wr_t cpu_q[$];
    wr_t exp_seq_q[$];
    wr_t seq_log[$];
    wr_t mw;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Step model: one animation step from the rules, plain arithmetic.
    function automatic int model_step(input int p, input bit incr);
        if (incr) return (p + 1) % 65536;
        return ((p * 2) % 65536) + (p / 32768);
    endfunction

    task automatic push_pair(input int p);
        exp_seq_q.push_back('{8'hC0, 8'(p % 256), 0});
        exp_seq_q.push_back('{8'hC1, 8'(p / 256), 0});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_cycle(input logic we, input logic [7:0] a, input logic [7:0] d);
        step();
        CPU_WE   = we;
        CPU_ADDR = a;
        CPU_DATA = d;
        if (we) cpu_q.push_back('{a, d, cyc});
    endtask

    task automatic idle(input int n);
        repeat (n) cpu_cycle(1'b0, 8'h00, 8'h00);
    endtask

    task automatic cfg(input logic [15:0] seed, input logic [7:0] per,
                       input logic [7:0] ctrl, output int n);
        cpu_cycle(1'b1, 8'hC6, seed[7:0]);
        cpu_cycle(1'b1, 8'hC7, seed[15:8]);
        cpu_cycle(1'b1, 8'hC5, per);
        cpu_cycle(1'b1, 8'hC4, ctrl);
        n = cyc;
    endtask

    task automatic finish_scn(input string nm);
        cpu_cycle(1'b1, 8'hC4, 8'h00);
        idle(12);
        chk({nm, "_pending_seq"}, exp_seq_q.size(), 0);
        exp_seq_q.delete();
    endtask

    task automatic chk_at(input string nm, input int idx, input int exp_c);
        if (seq_log.size() > idx) chk(nm, seq_log[idx].c, exp_c);
        else chk({nm, "_missing"}, seq_log.size(), idx + 1);
    endtask

    // Monitor: every BUS_WE is either the CPU write issued the previous
    // cycle or the next expected sequencer write.
    initial forever begin
        @(negedge CLK);
        if (!RESET) begin
            if (BUS_WE) begin
                if (cpu_q.size() > 0 && cpu_q[0].c == cyc - 1) begin
                    mw = cpu_q.pop_front();
                    chk("cpu_addr", BUS_ADDR, mw.addr);
                    chk("cpu_data", BUS_DATA, mw.data);
                end else begin
                    seq_log.push_back('{BUS_ADDR, BUS_DATA, cyc});
                    if (exp_seq_q.size() == 0) begin
                        chk("seq_unexpected_write", {BUS_ADDR, BUS_DATA}, 0);
                        if (BUS_ADDR == 8'h00 && BUS_DATA == 8'h00) begin
                            errors++;
                            $display("FAIL seq_unexpected_write actual=0000 required=none");
                        end
                    end else begin
                        mw = exp_seq_q.pop_front();
                        chk("seq_addr", BUS_ADDR, mw.addr);
                        chk("seq_data", BUS_DATA, mw.data);
                    end
                end
            end else if (cpu_q.size() > 0 && cpu_q[0].c == cyc - 1) begin
                mw = cpu_q.pop_front();
                chk("cpu_write_dropped", 0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int p;
        int pe;
        logic [15:0] seed;
        logic [7:0]  per;
        bit          mode;

        RESET    = 1'b1;
        CPU_WE   = 1'b0;
        CPU_ADDR = 8'h00;
        CPU_DATA = 8'h00;
        #12;
        chk("rst_bus_we", BUS_WE, 0);
        chk("rst_bus_addr", BUS_ADDR, 0);
        chk("rst_bus_data", BUS_DATA, 0);
        chk("rst_seq_active", SEQ_ACTIVE, 0);
        step();
        step();
        RESET = 1'b0;
        idle(3);

        // CPU writes to the LED addresses pass straight through while idle.
        cpu_cycle(1'b1, 8'hC0, 8'h5A);
        cpu_cycle(1'b1, 8'hC1, 8'hA5);
        idle(4);
        chk("idle_no_seq_write", seq_log.size(), 0);

        // Rotate run, PERIOD=2: pairs every 8 cycles.
        seq_log.delete();
        push_pair(16'h8001);
        push_pair(16'h0003);
        push_pair(16'h0006);
        cfg(16'h8001, 8'd2, 8'h01, n);
        idle(18);
        finish_scn("rot");
        chk("rot_count", seq_log.size(), 6);
        chk_at("rot_lo0_cyc", 0, n + 2);
        chk_at("rot_hi0_cyc", 1, n + 3);
        chk_at("rot_lo1_cyc", 2, n + 10);
        chk_at("rot_lo2_cyc", 4, n + 18);

        // Increment with wrap, PERIOD=1: pairs every 4 cycles.
        seq_log.delete();
        push_pair(16'hFFFF);
        push_pair(16'h0000);
        push_pair(16'h0001);
        cfg(16'hFFFF, 8'd1, 8'h03, n);
        idle(10);
        finish_scn("inc");
        chk("inc_count", seq_log.size(), 6);
        chk_at("inc_lo0_cyc", 0, n + 2);
        chk_at("inc_lo1_cyc", 2, n + 6);
        chk_at("inc_lo2_cyc", 4, n + 10);

        // Contention: three CPU writes while WR_LO is pending.
        seq_log.delete();
        push_pair(16'h3C5A);
        cfg(16'h3C5A, 8'd3, 8'h01, n);
        cpu_cycle(1'b1, 8'h10, 8'hA1);
        cpu_cycle(1'b1, 8'h11, 8'hB2);
        cpu_cycle(1'b1, 8'h12, 8'hC3);
        idle(2);
        finish_scn("cont");
        chk("cont_count", seq_log.size(), 2);
        chk_at("cont_lo_cyc", 0, n + 5);
        chk_at("cont_hi_cyc", 1, n + 6);

        // Disable written in the cycle WR_HI is entered.
        seq_log.delete();
        push_pair(16'hBEEF);
        cfg(16'hBEEF, 8'd1, 8'h01, n);
        chk("dis_active_at_en", SEQ_ACTIVE, 0);
        idle(1);
        chk("dis_active_rise", SEQ_ACTIVE, 1);
        cpu_cycle(1'b1, 8'hC4, 8'h00);
        idle(1);
        chk("dis_active_in_hi", SEQ_ACTIVE, 1);
        idle(1);
        chk("dis_active_fall", SEQ_ACTIVE, 0);
        idle(10);
        finish_scn("dis");
        chk("dis_count", seq_log.size(), 2);
        chk_at("dis_hi_cyc", 1, n + 4);

        // SEED_LO written in the expiry cycle: seed wins, period restarts.
        seq_log.delete();
        push_pair(16'h1234);
        push_pair(16'h1255);
        push_pair(16'h1256);
        cfg(16'h1234, 8'd2, 8'h03, n);
        idle(7);
        cpu_cycle(1'b1, 8'hC6, 8'h55);
        idle(10);
        finish_scn("seed");
        chk("seed_count", seq_log.size(), 6);
        chk_at("seed_lo1_cyc", 2, n + 10);
        chk_at("seed_lo2_cyc", 4, n + 18);

        // Asynchronous reset while the high byte is pending.
        seq_log.delete();
        exp_seq_q.push_back('{8'hC0, 8'hFF, 0});
        cfg(16'h00FF, 8'd1, 8'h01, n);
        idle(2);
        @(negedge CLK);
        #2;
        chk("rstmid_lo_seen", exp_seq_q.size(), 0);
        RESET = 1'b1;
        #1;
        chk("rstmid_bus_we", BUS_WE, 0);
        chk("rstmid_bus_addr", BUS_ADDR, 0);
        chk("rstmid_bus_data", BUS_DATA, 0);
        chk("rstmid_seq_active", SEQ_ACTIVE, 0);
        exp_seq_q.delete();
        cpu_q.delete();
        base = seq_log.size();
        step();
        step();
        RESET = 1'b0;
        idle(20);
        chk("rstmid_no_writes_after", seq_log.size(), base);

        // Randomised runs with background CPU traffic outside C0..C7.
        for (int t = 0; t < 6; t++) begin
            seed = 16'($urandom);
            per  = 8'($urandom_range(0, 3));
            mode = 1'($urandom_range(0, 1));
            pe   = (per == 8'd0) ? 1 : int'(per);
            p    = int'(seed);
            for (int k = 0; k < 40; k++) begin
                push_pair(p);
                p = model_step(p, mode);
            end
            seq_log.delete();
            cfg(seed, per, {6'd0, mode, 1'b1}, n);
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) == 0)
                    cpu_cycle(1'b1, 8'($urandom_range(0, 191)), 8'($urandom));
                else
                    idle(1);
            end
            cpu_cycle(1'b1, 8'hC4, 8'h00);
            idle(12);
            chk("rnd_pairs_complete", seq_log.size() % 2, 0);
            chk("rnd_min_pairs", int'(seq_log.size() >= 2), 1);
            chk("rnd_max_pairs", int'(seq_log.size() / 2 <= 2 + 72 / (pe * 4)), 1);
            exp_seq_q.delete();
        end

        chk("cpu_queue_drained", cpu_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
